// File: rtl/magnetron_ctrl.sv
// Microwave magnetron controller: synchronised, debounced buttons, a door-interlocked
// IDLE/COOK/PAUSE/DONE state machine, power-level PWM on the magnetron enable, and
// one-cycle set/reset pulses for the legacy SR-latch path.
module magnetron_ctrl #(
    parameter int DEB_CYCLES   = 4,
    parameter int PWR_W        = 3,
    parameter int PWM_PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clrn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             mag_on,
    output logic             set,
    output logic             reset,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [PWR_W-1:0] TICK_MAX = PWR_W'((1 << PWR_W) - 2);

    // Button index: 0 = start, 1 = stop, 2 = clear (all active-low on the pins)
    logic [2:0]       btn_p0, btn_p1;
    logic             door_p0, door_p1;
    logic [CNT_W-1:0] deb_cnt [3];
    logic [2:0]       deb_hit;
    logic [2:0]       press;

    state_t           state_q, state_nxt;
    logic [PWR_W-1:0] lvl_q, lvl_nxt;
    logic [PWR_W-1:0] tick_q, tick_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic             enter_cook, leave_cook;

    logic start_ev, stop_ev, clr_ev, door_ok;

    assign start_ev = press[0];
    assign stop_ev  = press[1];
    assign clr_ev   = press[2];
    assign door_ok  = door_p1;

    assign state = state_q;
    assign done  = (state_q == DONE);

    // Two-flop synchronisers; buttons clear to released, door clears to open (safe side)
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0  <= 3'b111;
            btn_p1  <= 3'b111;
            door_p0 <= 1'b0;
            door_p1 <= 1'b0;
        end else begin
            btn_p0  <= {clrn, stopn, startn};
            btn_p1  <= btn_p0;
            door_p0 <= door_closed;
            door_p1 <= door_p0;
        end
    end

    // Debounce: count consecutive low samples, strobe once the count has sat at its ceiling
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || btn_p1[i]) begin
                deb_cnt[i] <= '0;
                deb_hit[i] <= 1'b0;
                press[i]   <= 1'b0;
            end else begin
                if (deb_cnt[i] != CNT_MAX) deb_cnt[i] <= deb_cnt[i] + 1'b1;
                press[i]   <= (deb_cnt[i] == CNT_MAX) && !deb_hit[i];
                deb_hit[i] <= (deb_cnt[i] == CNT_MAX);
            end
        end
    end

    // Next-state logic; within a cycle clear beats door-open beats timer beats stop beats start
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ev && door_ok && !timer_done) state_nxt = COOK;
            end
            COOK: begin
                if (clr_ev)          state_nxt = IDLE;
                else if (!door_ok)   state_nxt = PAUSE;
                else if (timer_done) state_nxt = DONE;
                else if (stop_ev)    state_nxt = PAUSE;
            end
            PAUSE: begin
                if (clr_ev)                     state_nxt = IDLE;
                else if (timer_done)            state_nxt = DONE;
                else if (stop_ev)               state_nxt = IDLE;
                else if (start_ev && door_ok)   state_nxt = COOK;
            end
            DONE: begin
                if (clr_ev || !door_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_cook = (state_nxt == COOK) && (state_q != COOK);
    assign leave_cook = (state_q == COOK) && (state_nxt != COOK);

    // PWM frame: latch level and restart the frame on every entry, otherwise advance while cooking
    always_comb begin
        lvl_nxt  = lvl_q;
        tick_nxt = tick_q;
        pre_nxt  = pre_q;
        if (enter_cook) begin
            lvl_nxt  = power_level;
            tick_nxt = '0;
            pre_nxt  = '0;
        end else if (state_q == COOK) begin
            if (pre_q == PRE_MAX) begin
                pre_nxt  = '0;
                tick_nxt = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
            end else begin
                pre_nxt = pre_q + 1'b1;
            end
        end
    end

    // Control registers: state, PWM counters and the registered magnetron/pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            pre_q   <= '0;
            mag_on  <= 1'b0;
            set     <= 1'b0;
            reset   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tick_q  <= tick_nxt;
            pre_q   <= pre_nxt;
            mag_on  <= (state_nxt == COOK) && (tick_nxt < lvl_nxt);
            set     <= enter_cook;
            reset   <= leave_cook;
        end
    end

    // Latched power level is pure data; it only matters once COOK has been entered
    always_ff @(posedge clk) begin
        lvl_q <= lvl_nxt;
    end

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed testbench for magnetron_ctrl with default parameters (DEB_CYCLES=4, PWR_W=3, PRESCALE=1).
module tb_magnetron_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       startn, stopn, clrn, door_closed, timer_done;
    logic [2:0] power_level;
    logic       mag_on, set, reset, done;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    magnetron_ctrl #(.DEB_CYCLES(4), .PWR_W(3), .PWM_PRESCALE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .startn      (startn),
        .stopn       (stopn),
        .clrn        (clrn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .power_level (power_level),
        .mag_on      (mag_on),
        .set         (set),
        .reset       (reset),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 ns past the last edge for sampling/driving
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; startn = 1'b1; stopn = 1'b1; clrn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = 3'd0;
        step(2);
        rst = 1'b0;
        step(3);
    endtask

    // Hold start low long enough to enter COOK (event after edge 6, state on edge 7)
    task automatic enter_cook(input logic [2:0] lvl);
        power_level = lvl;
        startn = 1'b0;
        step(8);
        startn = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; startn = 1'b1; stopn = 1'b1; clrn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; power_level = 3'd0;
        step(2);
        rst = 1'b0;
        step(1);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %0b expected 00", state); end
        tests++; if (mag_on !== 1'b0) begin fails++; $display("FAIL reset_mag_on: got %0b expected 0", mag_on); end
        tests++; if (set !== 1'b0) begin fails++; $display("FAIL reset_set: got %0b expected 0", set); end
        tests++; if (reset !== 1'b0) begin fails++; $display("FAIL reset_reset: got %0b expected 0", reset); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    endtask

    task automatic test_start_latency();
        int bad;
        do_reset();
        power_level = 3'd7;
        startn = 1'b0;
        step(7);   // edges 0..6: press strobe only just raised
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL start_early: got %0b expected 00", state); end
        step(1);   // edge 7
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL start_state: got %0b expected 01", state); end
        tests++; if (set !== 1'b1) begin fails++; $display("FAIL start_set: got %0b expected 1", set); end
        tests++; if (mag_on !== 1'b1) begin fails++; $display("FAIL start_mag_on: got %0b expected 1", mag_on); end
        step(1);
        tests++; if (set !== 1'b0) begin fails++; $display("FAIL start_set_pulse: got %0b expected 0", set); end
        step(1);
        startn = 1'b1;   // held low for 10 clocks in total
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (mag_on !== 1'b1 || state !== 2'b01) bad++;
            step(1);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL full_power: got %0d off-cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_cook();
        rst = 1'b1;
        step(1);
        tests++; if (mag_on !== 1'b0) begin fails++; $display("FAIL midrst_mag_on: got %0b expected 0", mag_on); end
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL midrst_state: got %0b expected 00", state); end
        tests++; if (reset !== 1'b0) begin fails++; $display("FAIL midrst_reset: got %0b expected 0", reset); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_bounce();
        do_reset();
        power_level = 3'd7;
        for (int k = 0; k < 5; k++) begin
            startn = 1'b0;
            step(2);
            startn = 1'b1;
            step(2);
            tests++; if (state !== 2'b00) begin fails++; $display("FAIL bounce_%0d: got %0b expected 00", k, state); end
        end
        step(4);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL bounce_final: got %0b expected 00", state); end
    endtask

    task automatic test_pwm();
        logic exp;
        do_reset();
        power_level = 3'd3;
        startn = 1'b0;
        step(8);   // COOK entered on edge 7, tick 0
        for (int i = 0; i < 14; i++) begin
            exp = ((i % 7) < 3);
            tests++; if (mag_on !== exp) begin fails++; $display("FAIL pwm_%0d: got %0b expected %0b", i, mag_on, exp); end
            if (i == 2) startn = 1'b1;
            if (i == 4) power_level = 3'd7;   // must be ignored mid-cook
            step(1);
        end
    endtask

    task automatic test_door();
        do_reset();
        enter_cook(3'd7);
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL door_precook: got %0b expected 01", state); end
        door_closed = 1'b0;
        step(1);
        tests++; if (mag_on !== 1'b1) begin fails++; $display("FAIL door_edge0_mag: got %0b expected 1", mag_on); end
        step(2);
        tests++; if (state !== 2'b10) begin fails++; $display("FAIL door_pause: got %0b expected 10", state); end
        tests++; if (mag_on !== 1'b0) begin fails++; $display("FAIL door_mag_off: got %0b expected 0", mag_on); end
        tests++; if (reset !== 1'b1) begin fails++; $display("FAIL door_reset: got %0b expected 1", reset); end
        tests++; if (set !== 1'b0) begin fails++; $display("FAIL door_no_set: got %0b expected 0", set); end
        step(1);
        tests++; if (reset !== 1'b0) begin fails++; $display("FAIL door_reset_pulse: got %0b expected 0", reset); end
        // Start with door still open must not resume
        enter_cook(3'd7);
        tests++; if (state !== 2'b10) begin fails++; $display("FAIL door_open_start: got %0b expected 10", state); end
        door_closed = 1'b1;
        step(3);
        startn = 1'b0;
        step(8);
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL door_resume: got %0b expected 01", state); end
        tests++; if (set !== 1'b1) begin fails++; $display("FAIL door_resume_set: got %0b expected 1", set); end
        startn = 1'b1;
        step(2);
    endtask

    task automatic test_stop();
        do_reset();
        enter_cook(3'd7);
        stopn = 1'b0;
        step(8);
        tests++; if (state !== 2'b10) begin fails++; $display("FAIL stop_pause: got %0b expected 10", state); end
        tests++; if (reset !== 1'b1) begin fails++; $display("FAIL stop_reset: got %0b expected 1", reset); end
        step(4);   // button still held: exactly one event, stay in PAUSE
        tests++; if (state !== 2'b10) begin fails++; $display("FAIL stop_hold: got %0b expected 10", state); end
        stopn = 1'b1;
        step(2);
        stopn = 1'b0;
        step(8);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL stop_idle: got %0b expected 00", state); end
        stopn = 1'b1;
        step(2);
    endtask

    task automatic test_clear_timer();
        do_reset();
        enter_cook(3'd7);
        clrn = 1'b0;
        step(7);   // clear strobe raised after edge 6
        timer_done = 1'b1;
        step(1);
        timer_done = 1'b0;
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL clr_wins_state: got %0b expected 00", state); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL clr_wins_done: got %0b expected 0", done); end
        tests++; if (reset !== 1'b1) begin fails++; $display("FAIL clr_wins_reset: got %0b expected 1", reset); end
        clrn = 1'b1;
        step(2);
        enter_cook(3'd7);
        timer_done = 1'b1;
        step(1);
        timer_done = 1'b0;
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL timer_state: got %0b expected 11", state); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL timer_done: got %0b expected 1", done); end
        tests++; if (mag_on !== 1'b0) begin fails++; $display("FAIL timer_mag: got %0b expected 0", mag_on); end
        enter_cook(3'd7);   // start ignored in DONE
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL done_ignore_start: got %0b expected 11", state); end
        door_closed = 1'b0;
        step(3);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL done_door_idle: got %0b expected 00", state); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_door_done: got %0b expected 0", done); end
        door_closed = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_reset_mid_cook();
        test_bounce();
        test_pwm();
        test_door();
        test_stop();
        test_clear_timer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
